// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a fixed-latency DSP-style ALU: buffers host operand
// commands, issues them under result-credit control and returns tagged P values.
module alu_cmd_sequencer #(
    parameter int ALU_LAT   = 2,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_sel,
    input  logic [17:0]      cmd_a,
    input  logic [17:0]      cmd_b,
    input  logic [17:0]      cmd_d,
    input  logic [47:0]      cmd_c,
    input  logic             cmd_cin,
    output logic [17:0]      alu_a,
    output logic [17:0]      alu_b,
    output logic [17:0]      alu_d,
    output logic [47:0]      alu_c,
    output logic             alu_carryin,
    output logic [1:0]       alu_sel,
    output logic             alu_issue,
    input  logic [47:0]      alu_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);
    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int RES_AW = $clog2(RES_DEPTH);
    localparam int IF_W   = $clog2(ALU_LAT + 1);

    typedef struct packed {
        logic [1:0]  sel;
        logic [17:0] a;
        logic [17:0] b;
        logic [47:0] c;
        logic [17:0] d;
        logic        cin;
    } cmd_t;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
    } slot_t;

    cmd_t             cmd_mem      [CMD_DEPTH];
    logic [47:0]      res_data_mem [RES_DEPTH];
    logic [TAG_W-1:0] res_tag_mem  [RES_DEPTH];
    slot_t            pipe         [ALU_LAT];

    logic [CMD_AW:0]  cmd_wr, cmd_rd, cmd_count;
    logic [RES_AW:0]  res_wr, res_rd, res_count;
    logic [IF_W-1:0]  inflight;
    logic [TAG_W-1:0] tag_q;
    logic             ready_en;
    logic             cmd_push, cmd_empty, credit_ok, issue, capture, res_pop;
    cmd_t             cmd_head;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign cmd_count = cmd_wr - cmd_rd;
    assign res_count = res_wr - res_rd;
    assign cmd_empty = (cmd_wr == cmd_rd);
    assign cmd_ready = ready_en && (cmd_count != (CMD_AW+1)'(CMD_DEPTH));
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_head  = cmd_mem[cmd_rd[CMD_AW-1:0]];

    // Every issued command has a reserved result slot, so captures never overflow.
    assign credit_ok = (32'(res_count) + 32'(inflight)) < 32'(RES_DEPTH);
    assign issue     = !cmd_empty && credit_ok;
    assign capture   = pipe[ALU_LAT-1].vld;

    assign res_valid = (res_wr != res_rd);
    assign res_pop   = res_valid && res_ready;
    assign res_data  = res_valid ? res_data_mem[res_rd[RES_AW-1:0]] : '0;
    assign res_tag   = res_valid ? res_tag_mem[res_rd[RES_AW-1:0]]  : '0;
    assign busy      = !cmd_empty || (inflight != '0) || res_valid;

    // NOTE: storage arrays are not reset; only the pointers are, and the
    // output muxes hide stale entries while a FIFO is empty.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr[CMD_AW-1:0]] <= '{sel: cmd_sel, a: cmd_a, b: cmd_b,
                                             c: cmd_c, d: cmd_d, cin: cmd_cin};
        end
        if (capture) begin
            res_data_mem[res_wr[RES_AW-1:0]] <= alu_p;
            res_tag_mem[res_wr[RES_AW-1:0]]  <= pipe[ALU_LAT-1].tag;
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en    <= 1'b0;
            cmd_wr      <= '0;
            cmd_rd      <= '0;
            res_wr      <= '0;
            res_rd      <= '0;
            inflight    <= '0;
            tag_q       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_d       <= '0;
            alu_c       <= '0;
            alu_carryin <= 1'b0;
            alu_sel     <= '0;
            alu_issue   <= 1'b0;
            for (int i = 0; i < ALU_LAT; i++) pipe[i] <= '0;
        end else begin
            ready_en  <= 1'b1;
            alu_issue <= issue;
            if (cmd_push) cmd_wr <= cmd_wr + 1'b1;
            if (issue) begin
                cmd_rd      <= cmd_rd + 1'b1;
                alu_a       <= cmd_head.a;
                alu_b       <= cmd_head.b;
                alu_d       <= cmd_head.d;
                alu_c       <= cmd_head.c;
                alu_carryin <= cmd_head.cin;
                alu_sel     <= cmd_head.sel;
                tag_q       <= tag_q + 1'b1;
            end

            pipe[0] <= '{vld: issue, tag: tag_q};
            for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];

            case ({issue, capture})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase

            if (capture) res_wr <= res_wr + 1'b1;
            if (res_pop) res_rd <= res_rd + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-register ALU stub
// (operand registers plus one stage give ALU_LAT=2).
module tb_alu_cmd_sequencer;
    localparam int ALU_LAT   = 2;
    localparam int CMD_DEPTH = 4;
    localparam int RES_DEPTH = 4;
    localparam int TAG_W     = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0, cmd_ready;
    logic [1:0]       cmd_sel = '0;
    logic [17:0]      cmd_a = '0, cmd_b = '0, cmd_d = '0;
    logic [47:0]      cmd_c = '0;
    logic             cmd_cin = 1'b0;
    logic [17:0]      alu_a, alu_b, alu_d;
    logic [47:0]      alu_c;
    logic             alu_carryin, alu_issue;
    logic [1:0]       alu_sel;
    logic [47:0]      alu_p;
    logic             res_valid, res_ready = 1'b0;
    logic [47:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             busy;

    alu_cmd_sequencer #(
        .ALU_LAT(ALU_LAT), .CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_c(cmd_c), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d), .alu_c(alu_c),
        .alu_carryin(alu_carryin), .alu_sel(alu_sel), .alu_issue(alu_issue),
        .alu_p(alu_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] alu_fn(logic [1:0] sel, logic [17:0] a, logic [17:0] b,
                                           logic [17:0] d, logic [47:0] c, logic cin);
        logic [47:0] ae, be, de, ce;
        ae = {30'd0, a};
        be = {30'd0, b};
        de = {30'd0, d};
        ce = {47'd0, cin};
        case (sel)
            2'b00:   return ae * be + c + ce;
            2'b01:   return (de + ae) * be + c;
            2'b10:   return c - ae * be - ce;
            default: return c + de + ce;
        endcase
    endfunction

    logic [47:0] p_q;
    always @(posedge clk) p_q <= alu_fn(alu_sel, alu_a, alu_b, alu_d, alu_c, alu_carryin);
    assign alu_p = p_q;

    typedef struct {
        logic [1:0]  sel;
        logic [17:0] a;
        logic [17:0] b;
        logic [47:0] c;
        logic [17:0] d;
        logic        cin;
        logic [47:0] exp_p;
    } vec_t;

    typedef struct {
        logic [47:0]      data;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t             got_q[$];
    res_t             exp_q[$];
    int               issue_cyc_q[$];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [TAG_W-1:0] tag_ctr = '0;

    // Monitor samples one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        cyc++;
        if (rst_n) begin
            if (res_valid && res_ready) got_q.push_back('{res_data, res_tag});
            if (alu_issue) issue_cyc_q.push_back(cyc);
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        step(2);
        rst_n   = 1'b1;
        tag_ctr = '0;
        exp_q.delete();
    endtask

    task automatic push_cmd(logic [1:0] sel, logic [17:0] a, logic [17:0] b, logic [47:0] c,
                            logic [17:0] d, logic cin, logic [47:0] exp_p);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        cmd_c     = c;
        cmd_d     = d;
        cmd_cin   = cin;
        for (int t = 0; t < 200 && !cmd_ready; t++) step();
        if (!cmd_ready) begin
            check("push_ready", {63'd0, cmd_ready}, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        step();
        cmd_valid = 1'b0;
        exp_q.push_back('{exp_p, tag_ctr});
        tag_ctr++;
    endtask

    task automatic push_seq(int n);
        for (int i = 0; i < n; i++)
            push_cmd(2'b00, 18'(i + 1), 18'd2, 48'(i), 18'd0, 1'b0, 48'(3 * i + 2));
    endtask

    task automatic wait_idle(string name);
        for (int t = 0; t < 500 && busy; t++) step();
        check($sformatf("%s_idle", name), {63'd0, busy}, 64'd0);
    endtask

    task automatic compare_results(string name, int base);
        check($sformatf("%s_count", name), 64'(got_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                check($sformatf("%s_data%0d", name, i), 64'(got_q[base+i].data), 64'(exp_q[i].data));
                check($sformatf("%s_tag%0d", name, i), 64'(got_q[base+i].tag), 64'(exp_q[i].tag));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   gb, ib;

        vecs[0] = '{2'b00, 18'h5, 18'h7, 48'h10,   18'h0,  1'b1, 48'h34};
        vecs[1] = '{2'b01, 18'h2, 18'h4, 48'h1,    18'h3,  1'b0, 48'h15};
        vecs[2] = '{2'b10, 18'h3, 18'h5, 48'h100,  18'h0,  1'b1, 48'hF0};
        vecs[3] = '{2'b11, 18'h0, 18'h0, 48'h1000, 18'h20, 1'b1, 48'h1021};

        // Test 1: reset values and single-command latency.
        @(negedge clk);
        step(2);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_alu_issue", {63'd0, alu_issue}, 64'd0);
        rst_n = 1'b1;
        check("rel_cmd_ready_before_edge", {63'd0, cmd_ready}, 64'd0);
        step();
        check("rel_cmd_ready_after_edge", {63'd0, cmd_ready}, 64'd1);
        gb = got_q.size();
        push_cmd(2'b00, 18'h0000B, 18'h00003, 48'h1, 18'h3, 1'b0, 48'h22);
        check("t1_no_issue_yet", {63'd0, alu_issue}, 64'd0);
        step();
        check("t1_issue", {63'd0, alu_issue}, 64'd1);
        check("t1_alu_a", 64'(alu_a), 64'hB);
        check("t1_alu_b", 64'(alu_b), 64'h3);
        check("t1_alu_c", 64'(alu_c), 64'h1);
        check("t1_alu_d", 64'(alu_d), 64'h3);
        step();
        check("t1_issue_pulse", {63'd0, alu_issue}, 64'd0);
        check("t1_hold_a", 64'(alu_a), 64'hB);
        check("t1_res_not_yet", {63'd0, res_valid}, 64'd0);
        step();
        check("t1_res_valid", {63'd0, res_valid}, 64'd1);
        check("t1_res_data", 64'(res_data), 64'h22);
        check("t1_res_tag", 64'(res_tag), 64'd0);
        step();
        check("t1_res_stable", 64'(res_data), 64'h22);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t1_res_popped", {63'd0, res_valid}, 64'd0);
        check("t1_busy", {63'd0, busy}, 64'd0);
        compare_results("t1", gb);

        // Test 2: sel sweep from the vector table, back-to-back.
        do_reset();
        gb = got_q.size();
        ib = issue_cyc_q.size();
        res_ready = 1'b1;
        foreach (vecs[i])
            push_cmd(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].cin,
                     vecs[i].exp_p);
        wait_idle("t2");
        check("t2_issue_count", 64'(issue_cyc_q.size() - ib), 64'd4);
        if (issue_cyc_q.size() - ib == 4)
            check("t2_issue_back_to_back", 64'(issue_cyc_q[ib+3] - issue_cyc_q[ib]), 64'd3);
        compare_results("t2", gb);
        res_ready = 1'b0;

        // Test 3: result backpressure caps issues at RES_DEPTH credits.
        do_reset();
        gb = got_q.size();
        ib = issue_cyc_q.size();
        push_seq(8);
        step(4);
        check("t3_issues_capped", 64'(issue_cyc_q.size() - ib), 64'd4);
        check("t3_cmd_full", {63'd0, cmd_ready}, 64'd0);
        check("t3_res_valid", {63'd0, res_valid}, 64'd1);
        res_ready = 1'b1;
        wait_idle("t3");
        compare_results("t3", gb);
        res_ready = 1'b0;

        // Test 4: tag wraps after 2^TAG_W commands.
        do_reset();
        gb = got_q.size();
        res_ready = 1'b1;
        push_seq(17);
        wait_idle("t4");
        compare_results("t4", gb);
        if (got_q.size() - gb == 17) begin
            check("t4_tag15", 64'(got_q[gb+15].tag), 64'd15);
            check("t4_tag_wrap", 64'(got_q[gb+16].tag), 64'd0);
        end
        res_ready = 1'b0;

        // Test 5: asynchronous reset with work in flight.
        do_reset();
        push_seq(3);
        for (int t = 0; t < 20 && !res_valid; t++) step();
        check("t5_pre_res_valid", {63'd0, res_valid}, 64'd1);
        check("t5_pre_issue", {63'd0, alu_issue}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_issue", {63'd0, alu_issue}, 64'd0);
        check("t5_async_alu_a", 64'(alu_a), 64'd0);
        check("t5_async_alu_c", 64'(alu_c), 64'd0);
        check("t5_async_res_valid", {63'd0, res_valid}, 64'd0);
        check("t5_async_res_data", 64'(res_data), 64'd0);
        check("t5_async_busy", {63'd0, busy}, 64'd0);
        check("t5_async_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        tag_ctr = '0;
        exp_q.delete();
        gb = got_q.size();
        step(4);
        check("t5_no_stale_valid", {63'd0, res_valid}, 64'd0);
        check("t5_no_stale_busy", {63'd0, busy}, 64'd0);
        res_ready = 1'b1;
        push_cmd(2'b00, 18'h4, 18'h4, 48'h5, 18'h0, 1'b0, 48'h15);
        wait_idle("t5");
        compare_results("t5", gb);
        res_ready = 1'b0;

        // Test 6: host pop lands on the same edge as a capture.
        do_reset();
        gb = got_q.size();
        ib = issue_cyc_q.size();
        push_seq(5);
        step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t6_one_popped", 64'(got_q.size() - gb), 64'd1);
        check("t6_head_after_pop", 64'(res_tag), 64'd1);
        step(6);
        check("t6_issue_count", 64'(issue_cyc_q.size() - ib), 64'd5);
        check("t6_still_pending", {63'd0, res_valid}, 64'd1);
        res_ready = 1'b1;
        wait_idle("t6");
        compare_results("t6", gb);
        res_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
